if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It owns the PC register and the next-PC selection, and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC and PC+4 to the IF/ID pipeline register, honouring the hazard stall and the branch/jump redirect (flush) from the ID stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- stall  input  1  hazard stall from hazard unit; hold fetch outputs
- redirect_valid  input  1  taken branch/jump from ID; flush wrong-path fetch
- redirect_target  input  32  new PC when redirect_valid=1
- imem_req  output  1  instruction read request
- imem_addr  output  32  word-aligned read address, equal to the current PC
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- instruction_out  output  32  fetched instruction to IF/ID
- pc_out  output  32  address of instruction_out
- pc_plus4_out  output  32  pc_out+4 to IF/ID
- fetch_valid  output  1  instruction_out is a real instruction (0 = bubble)

## Operation
- State: pc (32), FSM {FETCH, HOLD, DRAIN}, hold buffer (instr 32, pc 32).
- FETCH: imem_req=1, imem_addr=pc. An ack may arrive in the same cycle as req (zero-wait memory) or any later cycle. req and addr stay stable until ack.
  - ack, stall=0, no redirect: instruction_out<=imem_rdata, pc_out<=pc, pc_plus4_out<=pc+4, fetch_valid<=1, pc<=pc+4; remain in FETCH.
  - ack, stall=1, no redirect: capture {imem_rdata, pc} into the hold buffer and go to HOLD. Outputs are unchanged.
  - no ack, stall=0: fetch_valid<=0 (bubble); other outputs hold.
  - no ack, stall=1: all outputs hold.
- HOLD: imem_req=0. While stall=1, remain and hold the outputs. When stall=0, load the outputs from the buffer (fetch_valid<=1, pc_plus4_out<=buffer pc+4), set pc<=buffer pc+4, and go to FETCH.
- Redirect (redirect_valid=1) has priority over stall and ack:
  - pc<=redirect_target with bits [1:0] forced to 00.
  - fetch_valid<=0; the hold buffer is discarded.
  - From FETCH without ack this cycle: go to DRAIN.
  - From FETCH with ack this cycle: discard the data and stay in FETCH, so the new address is issued next cycle.
  - From HOLD: go to FETCH.
  - From DRAIN: update pc only and stay in DRAIN.
- DRAIN: imem_req=1, imem_addr = the stale address, latched on entry. On ack, discard the data and go to FETCH. fetch_valid stays 0.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (async, any state):
  - pc=RESET_PC, FSM=FETCH.
  - instruction_out=0, pc_out=0, pc_plus4_out=0, fetch_valid=0.
  - imem_req=0 while reset is asserted; it rises in the first cycle after deassertion.
  - Any in-flight memory request is abandoned; the memory must tolerate this.
- Latency: with zero-wait memory, the instruction at pc appears on the outputs at the next clock edge. Throughput is 1 instruction/cycle.
- With N wait cycles, there are N bubbles (fetch_valid=0) per instruction.
- Redirect to the first target instruction on the outputs:
  - Ack or zero-wait in the redirect cycle: 2 edges.
  - Otherwise: 2 edges plus the remaining drain wait.
- Stall deasserting in HOLD: the buffered instruction appears at the next edge with no refetch.

## Test plan
- Zero-wait sequential:
  - Stimulus: reset, RESET_PC=0, ack tied to req, memory returns addr^32'hA5A5_0000.
  - Required: fetch_valid=1 from the 2nd post-reset edge; pc_out 0,4,8,C on consecutive cycles; pc_plus4_out=pc_out+4.
- Wait states:
  - Stimulus: ack 2 cycles after each req.
  - Required: each instruction is preceded by 2 bubble cycles; imem_addr is stable while req is held; no address is skipped or duplicated.
- Stall capture:
  - Stimulus: stall=1 in the cycle ack returns instruction at 0x10; hold stall 3 cycles.
  - Required: imem_req=0 during HOLD; outputs are frozen; when stall falls, pc_out=0x10 at the next edge, then a fetch at 0x14.
- Redirect with outstanding request:
  - Stimulus: redirect_valid with target 0x103 while a request at 0x20 is pending; ack arrives 2 cycles later.
  - Required: fetch_valid=0; the 0x20 data is discarded; the next imem_addr is 0x100; pc_out=0x100 follows.
- Simultaneous redirect, stall and ack:
  - Required: the redirect wins; no instruction is captured; the next request goes to the target.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC; fetch 2 instructions; then assert reset mid-request between edges.
  - Required: pc_out goes FFFF_FFFC then 0000_0000. On reset, all outputs clear immediately without waiting for a clock edge, and imem_req drops.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction
// memory over a req/ack handshake, and hands {instruction, pc, pc+4} to the
// IF/ID register. Handles hazard stall (hold buffer) and ID-stage redirect
// (drain of a stale outstanding read).
//
// state    | meaning
// ---------+----------------------------------------------------------------
// FETCH    | request at r_pc; on ack present or buffer the word
// HOLD     | word captured during a stall; no request until stall drops
// DRAIN    | stale request still outstanding after a redirect; drop its data
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_valid
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_pc4_out;
  logic        r_valid;
  // Goes high on the first edge after reset release; keeps the request low
  // for that first cycle so memory sees a clean start.
  logic        r_started;

  logic        w_ack;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_buf_pc_plus4;

  assign w_ack          = imem_ack & r_started;
  assign w_redirect_pc  = redirect_target & 32'hFFFF_FFFC;
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_buf_pc_plus4 = r_buf_pc + 32'd4;

  assign instruction_out = r_instr;
  assign pc_out          = r_pc_out;
  assign pc_plus4_out    = r_pc4_out;
  assign fetch_valid     = r_valid;

  // Memory request: active in FETCH and DRAIN; DRAIN keeps the stale address.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    if (r_started) begin
      case (r_state)
        ST_FETCH: imem_req = 1'b1;
        ST_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = r_drain_addr;
        end
        default:  imem_req = 1'b0;
      endcase
    end
  end

  // PC, FSM, hold buffer and IF/ID outputs; redirect outranks stall and ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_buf_instr  <= 32'd0;
      r_buf_pc     <= 32'd0;
      r_drain_addr <= 32'd0;
      r_instr      <= 32'd0;
      r_pc_out     <= 32'd0;
      r_pc4_out    <= 32'd0;
      r_valid      <= 1'b0;
      r_started    <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (redirect_valid) begin
        r_pc    <= w_redirect_pc;
        r_valid <= 1'b0;
        case (r_state)
          ST_FETCH: begin
            // A request that has not completed must be drained before the
            // new address can go out; an acked one is simply dropped.
            if (!w_ack && r_started) begin
              r_drain_addr <= r_pc;
              r_state      <= ST_DRAIN;
            end
          end
          ST_HOLD:  r_state <= ST_FETCH;
          ST_DRAIN: r_state <= ST_DRAIN;
          default:  r_state <= ST_FETCH;
        endcase
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (w_ack) begin
              if (!stall) begin
                r_instr   <= imem_rdata;
                r_pc_out  <= r_pc;
                r_pc4_out <= w_pc_plus4;
                r_valid   <= 1'b1;
                r_pc      <= w_pc_plus4;
              end else begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_pc;
                r_state     <= ST_HOLD;
              end
            end else if (!stall) begin
              r_valid <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              r_instr   <= r_buf_instr;
              r_pc_out  <= r_buf_pc;
              r_pc4_out <= w_buf_pc_plus4;
              r_valid   <= 1'b1;
              r_pc      <= w_buf_pc_plus4;
              r_state   <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (w_ack) begin
              r_state <= ST_FETCH;
            end
          end
          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a small memory model acks each request
// after wait_n cycles and returns addr ^ 32'hA5A5_0000.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        fetch_valid;

  int n_vec;
  int n_err;
  int wait_n;
  int mem_cnt;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .fetch_valid     (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once req has been held wait_n cycles.
  assign imem_ack   = imem_req && (mem_cnt == wait_n);
  assign imem_rdata = imem_addr ^ XORK;

  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; wait_n = 0;
    tick(); tick();
    n_vec++; if (instruction_out !== 32'd0) begin n_err++; $display("FAIL rst_instr got %h exp %h", instruction_out, 32'd0); end
    n_vec++; if (pc_out !== 32'd0) begin n_err++; $display("FAIL rst_pc got %h exp %h", pc_out, 32'd0); end
    n_vec++; if (pc_plus4_out !== 32'd0) begin n_err++; $display("FAIL rst_pc4 got %h exp %h", pc_plus4_out, 32'd0); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", fetch_valid); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    reset = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rel_req_low got %b exp 0", imem_req); end
  endtask

  task automatic test_zero_wait();
    tick();
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL zw_first_valid got %b exp 0", fetch_valid); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL zw_req got %b exp 1", imem_req); end
    n_vec++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL zw_addr got %h exp %h", imem_addr, 32'd0); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] epc;
      epc = 32'(k * 4);
      tick();
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d] got %b exp 1", k, fetch_valid); end
      n_vec++; if (pc_out !== epc) begin n_err++; $display("FAIL zw_pc[%0d] got %h exp %h", k, pc_out, epc); end
      n_vec++; if (pc_plus4_out !== epc + 32'd4) begin n_err++; $display("FAIL zw_pc4[%0d] got %h exp %h", k, pc_plus4_out, epc + 32'd4); end
      n_vec++; if (instruction_out !== (epc ^ XORK)) begin n_err++; $display("FAIL zw_instr[%0d] got %h exp %h", k, instruction_out, epc ^ XORK); end
    end
  endtask

  task automatic test_stall_capture();
    stall = 1'b1;
    n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL st_addr got %h exp %h", imem_addr, 32'h10); end
    n_vec++; if (imem_ack !== 1'b1) begin n_err++; $display("FAIL st_ack got %b exp 1", imem_ack); end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 2) stall = 1'b0;
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_hold_req[%0d] got %b exp 0", c, imem_req); end
      n_vec++; if (pc_out !== 32'hC) begin n_err++; $display("FAIL st_frozen_pc[%0d] got %h exp %h", c, pc_out, 32'hC); end
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL st_frozen_valid[%0d] got %b exp 1", c, fetch_valid); end
      n_vec++; if (instruction_out !== (32'hC ^ XORK)) begin n_err++; $display("FAIL st_frozen_instr[%0d] got %h exp %h", c, instruction_out, 32'hC ^ XORK); end
    end
    tick();
    n_vec++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL st_release_pc got %h exp %h", pc_out, 32'h10); end
    n_vec++; if (pc_plus4_out !== 32'h14) begin n_err++; $display("FAIL st_release_pc4 got %h exp %h", pc_plus4_out, 32'h14); end
    n_vec++; if (instruction_out !== (32'h10 ^ XORK)) begin n_err++; $display("FAIL st_release_instr got %h exp %h", instruction_out, 32'h10 ^ XORK); end
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL st_release_valid got %b exp 1", fetch_valid); end
    n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== 32'h14)) begin n_err++; $display("FAIL st_next_fetch got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 32'h14); end
    tick();
    n_vec++; if (pc_out !== 32'h14) begin n_err++; $display("FAIL st_next_pc got %h exp %h", pc_out, 32'h14); end
  endtask

  task automatic test_wait_states();
    wait_n = 2;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] ea;
      ea = 32'h18 + 32'(i * 4);
      for (int j = 0; j < 2; j++) begin
        n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== ea)) begin n_err++; $display("FAIL ws_addr[%0d.%0d] got req=%b addr=%h exp req=1 addr=%h", i, j, imem_req, imem_addr, ea); end
        tick();
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL ws_bubble[%0d.%0d] got %b exp 0", i, j, fetch_valid); end
      end
      n_vec++; if (imem_addr !== ea) begin n_err++; $display("FAIL ws_addr_ack[%0d] got %h exp %h", i, imem_addr, ea); end
      tick();
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL ws_valid[%0d] got %b exp 1", i, fetch_valid); end
      n_vec++; if (pc_out !== ea) begin n_err++; $display("FAIL ws_pc[%0d] got %h exp %h", i, pc_out, ea); end
      n_vec++; if (instruction_out !== (ea ^ XORK)) begin n_err++; $display("FAIL ws_instr[%0d] got %h exp %h", i, instruction_out, ea ^ XORK); end
    end
  endtask

  task automatic test_redirect_outstanding();
    n_vec++; if ((imem_addr !== 32'h20) || (imem_ack !== 1'b0)) begin n_err++; $display("FAIL rd_pending got addr=%h ack=%b exp addr=%h ack=0", imem_addr, imem_ack, 32'h20); end
    redirect_valid = 1'b1; redirect_target = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid0 got %b exp 0", fetch_valid); end
    n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== 32'h20)) begin n_err++; $display("FAIL rd_drain_addr got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 32'h20); end
    tick();
    n_vec++; if ((imem_addr !== 32'h20) || (imem_ack !== 1'b1)) begin n_err++; $display("FAIL rd_drain_ack got addr=%h ack=%b exp addr=%h ack=1", imem_addr, imem_ack, 32'h20); end
    tick();
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rd_discard got %b exp 0", fetch_valid); end
    n_vec++; if (pc_out !== 32'h1C) begin n_err++; $display("FAIL rd_discard_pc got %h exp %h", pc_out, 32'h1C); end
    n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== 32'h100)) begin n_err++; $display("FAIL rd_new_addr got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 32'h100); end
    wait_n = 0;
    tick();
    n_vec++; if ((fetch_valid !== 1'b1) || (pc_out !== 32'h100)) begin n_err++; $display("FAIL rd_target got valid=%b pc=%h exp valid=1 pc=%h", fetch_valid, pc_out, 32'h100); end
    n_vec++; if (instruction_out !== (32'h100 ^ XORK)) begin n_err++; $display("FAIL rd_target_instr got %h exp %h", instruction_out, 32'h100 ^ XORK); end
  endtask

  task automatic test_redirect_stall_ack();
    n_vec++; if ((imem_addr !== 32'h104) || (imem_ack !== 1'b1)) begin n_err++; $display("FAIL rsa_setup got addr=%h ack=%b exp addr=%h ack=1", imem_addr, imem_ack, 32'h104); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rsa_valid got %b exp 0", fetch_valid); end
    n_vec++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL rsa_pc_hold got %h exp %h", pc_out, 32'h100); end
    n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== 32'h200)) begin n_err++; $display("FAIL rsa_next_req got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 32'h200); end
    tick();
    n_vec++; if ((fetch_valid !== 1'b1) || (pc_out !== 32'h200)) begin n_err++; $display("FAIL rsa_target got valid=%b pc=%h exp valid=1 pc=%h", fetch_valid, pc_out, 32'h200); end
  endtask

  task automatic test_wrap_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr got %h exp %h", imem_addr, 32'hFFFF_FFFC); end
    tick();
    n_vec++; if ((pc_out !== 32'hFFFF_FFFC) || (pc_plus4_out !== 32'h0)) begin n_err++; $display("FAIL wr_top got pc=%h pc4=%h exp pc=%h pc4=%h", pc_out, pc_plus4_out, 32'hFFFF_FFFC, 32'h0); end
    n_vec++; if (instruction_out !== 32'h5A5A_FFFC) begin n_err++; $display("FAIL wr_top_instr got %h exp %h", instruction_out, 32'h5A5A_FFFC); end
    tick();
    n_vec++; if ((pc_out !== 32'h0) || (pc_plus4_out !== 32'h4) || (fetch_valid !== 1'b1)) begin n_err++; $display("FAIL wr_wrapped got pc=%h pc4=%h valid=%b exp pc=0 pc4=4 valid=1", pc_out, pc_plus4_out, fetch_valid); end
    wait_n = 2;
    #3;
    n_vec++; if ((imem_req !== 1'b1) || (imem_addr !== 32'h4)) begin n_err++; $display("FAIL wr_pending got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ar_req got %b exp 0", imem_req); end
    n_vec++; if ((pc_out !== 32'h0) || (pc_plus4_out !== 32'h0) || (instruction_out !== 32'h0) || (fetch_valid !== 1'b0)) begin n_err++; $display("FAIL ar_outputs got pc=%h pc4=%h instr=%h valid=%b exp all 0", pc_out, pc_plus4_out, instruction_out, fetch_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_zero_wait();
    test_stall_capture();
    test_wait_states();
    test_redirect_outstanding();
    test_redirect_stall_ack();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
